// File: rtl/ddr_stat_pkg.sv
// Shared types and default widths for the sh_ddr stat-bus initiator.
package ddr_stat_pkg;
  localparam int STAT_ADDR_W  = 8;
  localparam int STAT_DATA_W  = 32;
  localparam int STAT_INT_W   = 8;
  localparam int STAT_TIMEOUT = 1024;
  localparam int TCNT_W       = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} stat_state_e;

  typedef struct packed {
    logic                   wr;
    logic [STAT_ADDR_W-1:0] addr;
    logic [STAT_DATA_W-1:0] wdata;
  } stat_cmd_t;
endpackage

// File: rtl/ddr_stat_timer.sv
// Ack wait timer: cleared on load, counts while enabled, flags the cycle whose increment hits TIMEOUT_CYC-1.
module ddr_stat_timer
  import ddr_stat_pkg::*;
#(
  parameter int TIMEOUT_CYC = STAT_TIMEOUT
) (
  input  logic clk_i,
  input  logic sync_rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  logic [TCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  // Terminal when this cycle's increment reaches TIMEOUT_CYC-1.
  assign tc_o = en_i && (cnt_q == TCNT_W'(TIMEOUT_CYC - 2));
endmodule

// File: rtl/ddr_stat_master.sv
// CL-side initiator for one sh_ddr stat/config channel: one outstanding command, ack wait with timeout, sticky interrupts.
module ddr_stat_master
  import ddr_stat_pkg::*;
#(
  parameter int ADDR_W      = STAT_ADDR_W,
  parameter int DATA_W      = STAT_DATA_W,
  parameter int INT_W       = STAT_INT_W,
  parameter int TIMEOUT_CYC = STAT_TIMEOUT
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] stat_addr,
  output logic              stat_wr,
  output logic              stat_rd,
  output logic [DATA_W-1:0] stat_wdata,
  input  logic              stat_ack,
  input  logic [DATA_W-1:0] stat_rdata,
  input  logic [INT_W-1:0]  stat_int,
  output logic [INT_W-1:0]  int_status,
  input  logic [INT_W-1:0]  int_clr,
  output logic [15:0]       timeout_cnt
);
  stat_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              stat_wr_q, stat_wr_d;
  logic              stat_rd_q, stat_rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [INT_W-1:0]  int_q, int_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic              tmr_load, tmr_en, tmr_tc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  ddr_stat_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_i      (clk),
    .sync_rst_i (sync_rst),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    stat_wr_d = 1'b0;
    stat_rd_d = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    int_d     = (int_q & ~int_clr) | stat_int;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !sync_rst;
        if (cmd_valid && !sync_rst) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wr_d      = cmd_wr;
          stat_wr_d = cmd_wr;
          stat_rd_d = !cmd_wr;
          state_d   = REQ;
        end
      end
      REQ: begin
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        // Ack takes priority over a simultaneous timer expiry.
        if (stat_ack) begin
          rdata_d = wr_q ? '0 : stat_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmr_tc) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tcnt_d  = sat_inc16(tcnt_q);
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      stat_wr_q <= 1'b0;
      stat_rd_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      int_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      int_q     <= int_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign stat_addr   = addr_q;
  assign stat_wdata  = wdata_q;
  assign stat_wr     = stat_wr_q;
  assign stat_rd     = stat_rd_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign int_status  = int_q;
  assign timeout_cnt = tcnt_q;
endmodule

// File: tb/tb_ddr_stat_master.sv
// Directed bench for ddr_stat_master: per-cycle vector table plus hand sequences for timeout, race, backpressure and reset.
module tb_ddr_stat_master;
  logic        clk = 1'b0;
  logic        sync_rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  stat_addr;
  logic        stat_wr, stat_rd, stat_ack;
  logic [31:0] stat_wdata, stat_rdata;
  logic [7:0]  stat_int, int_status, int_clr;
  logic [15:0] timeout_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ddr_stat_master #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .sync_rst(sync_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stat_addr(stat_addr), .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_wdata(stat_wdata),
    .stat_ack(stat_ack), .stat_rdata(stat_rdata), .stat_int(stat_int),
    .int_status(int_status), .int_clr(int_clr), .timeout_cnt(timeout_cnt)
  );

  typedef struct packed {
    logic        rst, cv, cw;
    logic [7:0]  ca;
    logic [31:0] cd;
    logic        rr, ack;
    logic [31:0] sr;
    logic [7:0]  si, ic;
    logic        e_crdy, e_rv;
    logic [31:0] e_rd;
    logic        e_err, e_sw, e_srd;
    logic [7:0]  e_sa;
    logic [31:0] e_swd;
    logic [7:0]  e_int;
    logic [15:0] e_tc;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; stat_ack = 1'b0; stat_rdata = 32'h0;
    stat_int = 8'h00; int_clr = 8'h00;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    #1;
    chk("issue_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [116:0] got_v, exp_v;
  int n;

  initial begin
    // rst cv cw ca cd rr ack sr si ic | crdy rv rd err sw srd sa swd int tc
    tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,8'h00,32'h0,8'h00,16'h0};
    tbl[1]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,8'h00,32'h0,8'h00,16'h0};
    tbl[2]  = '{1'b0,1'b1,1'b1,8'h10,32'hDEADBEEF,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,8'h00,32'h0,8'h00,16'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b0,1'b0,32'h0,1'b0,1'b1,1'b0,8'h10,32'hDEADBEEF,8'h00,16'h0};
    tbl[4]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,8'h10,32'hDEADBEEF,8'h00,16'h0};
    tbl[5]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b1,32'hFFFFFFFF,8'h00,8'h00, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,8'h10,32'hDEADBEEF,8'h00,16'h0};
    tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b1,1'b0,32'h0,8'h00,8'h00, 1'b0,1'b1,32'h0,1'b0,1'b0,1'b0,8'h10,32'hDEADBEEF,8'h00,16'h0};
    tbl[7]  = '{1'b0,1'b1,1'b0,8'h04,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,8'h10,32'hDEADBEEF,8'h00,16'h0};
    tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,8'h04,32'h0,8'h00,16'h0};
    tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b1,32'h12345678,8'h00,8'h00, 1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,8'h04,32'h0,8'h00,16'h0};
    tbl[10] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b1,1'b0,32'h0,8'h00,8'h00, 1'b0,1'b1,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h00,16'h0};
    tbl[11] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h05,8'h00, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h00,16'h0};
    tbl[12] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h01, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h05,16'h0};
    tbl[13] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h04,16'h0};
    tbl[14] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h04,8'h04, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h04,16'h0};
    tbl[15] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h04,16'h0};
    tbl[16] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'hFF, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h04,16'h0};
    tbl[17] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h00,16'h0};
    tbl[18] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b1,32'hAAAAAAAA,8'h00,8'h00, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h00,16'h0};
    tbl[19] = '{1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,1'b0,32'h0,8'h00,8'h00, 1'b1,1'b0,32'h12345678,1'b0,1'b0,1'b0,8'h04,32'h0,8'h00,16'h0};

    sync_rst = 1'b1;
    idle_in();
    tick();
    tick();

    for (int i = 0; i < NV; i++) begin
      sync_rst  = tbl[i].rst;
      cmd_valid = tbl[i].cv;  cmd_wr = tbl[i].cw; cmd_addr = tbl[i].ca; cmd_wdata = tbl[i].cd;
      rsp_ready = tbl[i].rr;  stat_ack = tbl[i].ack; stat_rdata = tbl[i].sr;
      stat_int  = tbl[i].si;  int_clr = tbl[i].ic;
      #1;
      got_v = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, stat_wr, stat_rd, stat_addr, stat_wdata, int_status, timeout_cnt};
      exp_v = {tbl[i].e_crdy, tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_err, tbl[i].e_sw, tbl[i].e_srd,
               tbl[i].e_sa, tbl[i].e_swd, tbl[i].e_int, tbl[i].e_tc};
      vec_cnt++;
      if (got_v !== exp_v) begin
        err_cnt++;
        $display("FAIL row %0d: got %h expected %h", i, got_v, exp_v);
      end
      tick();
    end
    idle_in();

    // Timeout: no ack, response 16 cycles after the REQ cycle.
    issue(1'b0, 8'h20, 32'h0);
    chk("to_stat_rd", {63'd0, stat_rd}, 64'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", 64'(n), 64'd16);
    chk("to_err", {63'd0, rsp_err}, 64'd1);
    chk("to_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("to_cnt", {48'd0, timeout_cnt}, 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; stat_ack = 1'b1; stat_rdata = 32'h55555555;
    #1;
    chk("late_ack_rv0", {63'd0, rsp_valid}, 64'd0);
    tick();
    stat_ack = 1'b0;
    chk("late_ack_rv1", {62'd0, rsp_valid, cmd_ready}, 64'd1);
    chk("late_ack_rdata", {32'd0, rsp_rdata}, 64'd0);
    tick();
    chk("late_ack_rv2", {63'd0, rsp_valid}, 64'd0);

    // Ack in the terminal-count cycle wins.
    issue(1'b0, 8'h24, 32'h0);
    for (int k = 0; k < 14; k++) tick();
    chk("race_pre_rv", {63'd0, rsp_valid}, 64'd0);
    tick();
    stat_ack = 1'b1; stat_rdata = 32'hCAFEF00D;
    tick();
    stat_ack = 1'b0; stat_rdata = 32'h0;
    chk("race_rv", {63'd0, rsp_valid}, 64'd1);
    chk("race_err", {63'd0, rsp_err}, 64'd0);
    chk("race_rdata", {32'd0, rsp_rdata}, 64'hCAFEF00D);
    chk("race_cnt", {48'd0, timeout_cnt}, 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Backpressure with a second command pending.
    issue(1'b1, 8'h30, 32'h11112222);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h40; cmd_wdata = 32'h0;
    #1;
    chk("bp_req_crdy", {62'd0, cmd_ready, stat_wr}, 64'd1);
    tick();
    stat_ack = 1'b1; stat_rdata = 32'h99999999;
    chk("bp_wait_crdy", {63'd0, cmd_ready}, 64'd0);
    tick();
    stat_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", {29'd0, cmd_ready, rsp_valid, rsp_err, rsp_rdata}, {29'd0, 1'b0, 1'b1, 1'b0, 32'h0});
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_rv", {62'd0, rsp_valid, cmd_ready}, 64'd2);
    tick();
    rsp_ready = 1'b0;
    chk("bp_second_accept", {62'd0, cmd_ready, rsp_valid}, 64'd2);
    tick();
    cmd_valid = 1'b0;
    chk("bp_second_req", {55'd0, stat_rd, stat_addr}, {55'd0, 1'b1, 8'h40});
    tick();
    stat_ack = 1'b1; stat_rdata = 32'h00000005;
    tick();
    stat_ack = 1'b0;
    chk("bp_second_rsp", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, 32'h5});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during WAIT abandons the transaction.
    stat_int = 8'h08;
    issue(1'b0, 8'h50, 32'h0);
    stat_int = 8'h00;
    chk("rst_pre_int", {56'd0, int_status}, 64'h08);
    tick();
    sync_rst = 1'b1;
    tick();
    got_v = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, stat_wr, stat_rd, stat_addr, stat_wdata, int_status, timeout_cnt};
    vec_cnt++;
    if (got_v !== 117'd0) begin
      err_cnt++;
      $display("FAIL rst_wait_outputs: got %h expected 0", got_v);
    end
    sync_rst = 1'b0; stat_ack = 1'b1; stat_rdata = 32'h77777777;
    tick();
    stat_ack = 1'b0;
    chk("rst_late_ack_rv0", {62'd0, rsp_valid, cmd_ready}, 64'd1);
    tick();
    chk("rst_late_ack_rv1", {31'd0, rsp_valid, rsp_rdata}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/ddr_stat_master.md
Name: ddr_stat_master

Overview:
- CL-side initiator for the sh_ddr per-channel stat/config bus (addr/wr/rd/wdata out; ack/rdata/int in). It is the requesting end of the interface the shell answers.
- Converts a valid/ready command stream from CL control logic into single-cycle stat-bus write or read strobes and waits for ack.
- Returns rdata, or a timeout error, on a valid/ready response channel.
- Also captures the stat_int vector into sticky status bits.
- Sits between the CL register/OCL decode logic and one sh_ddr channel's stat port; one instance per DDR channel.

Parameters:
- ADDR_W, 8, stat-bus address width.
- DATA_W, 32, stat-bus data width.
- INT_W, 8, interrupt vector width.
- TIMEOUT_CYC, 1024, cycles to wait for ack before aborting; legal range 2..65535.

Ports:
- clk  in  1  single clock; stat bus and command/response channels are all synchronous to it.
- sync_rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_err  out  1  1 = timeout, no ack received.
- stat_addr  out  ADDR_W  stat-bus address.
- stat_wr  out  1  one-cycle write strobe.
- stat_rd  out  1  one-cycle read strobe.
- stat_wdata  out  DATA_W  stat-bus write data.
- stat_ack  in  1  one-cycle completion from the responder.
- stat_rdata  in  DATA_W  read data, valid in the ack cycle.
- stat_int  in  INT_W  level/pulse interrupt vector from the responder.
- int_status  out  INT_W  sticky OR of stat_int.
- int_clr  in  INT_W  per-bit write-1-to-clear for int_status.
- timeout_cnt  out  16  saturating count of timed-out transactions.

Behaviour:
- Reset values (sync_rst high at a clk edge):
  - state = IDLE.
  - cmd_ready = 0 during reset, 1 in the cycle after reset.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - stat_wr = 0, stat_rd = 0, stat_addr = 0, stat_wdata = 0.
  - int_status = 0, timeout_cnt = 0.
- Reset mid-transaction abandons the transaction with no response; a late ack after reset is ignored.
- FSM state IDLE:
  - cmd_ready = 1.
  - On cmd accept: register addr, wdata and wr into the stat_* outputs; go to REQ.
- FSM state REQ (exactly one cycle):
  - stat_wr = cmd_wr and stat_rd = !cmd_wr, both registered outputs.
  - Clear the wait counter; go to WAIT.
  - stat_addr and stat_wdata are held from REQ through the end of WAIT.
- FSM state WAIT:
  - stat_wr = stat_rd = 0. Increment the wait counter each cycle.
  - If stat_ack: capture stat_rdata (reads) or 0 (writes) into rsp_rdata; rsp_err = 0; go to RESP.
  - Else if the counter reaches TIMEOUT_CYC-1: rsp_rdata = 0, rsp_err = 1, timeout_cnt += 1 (saturating at 16'hFFFF); go to RESP.
  - If ack arrives in the same cycle the counter expires, ack wins and there is no error.
- FSM state RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_ready: rsp_valid falls next cycle; return to IDLE.
  - Backpressure of any length is allowed.
- Latency:
  - The strobe appears 1 cycle after cmd accept.
  - rsp_valid rises 1 cycle after the ack cycle.
  - Minimum accept-to-response is 3 cycles when ack arrives in the cycle after the strobe.
- Exactly one outstanding transaction. cmd_ready = 0 in REQ, WAIT and RESP.
- stat_ack in IDLE, REQ or RESP is spurious: ignore it and leave response data unchanged.
- int_status:
  - Update every cycle: int_status <= (int_status & ~int_clr) | stat_int.
  - Set wins over clear on the same bit in the same cycle.
  - Independent of the FSM; not affected by timeouts.

Decomposition:
- Package ddr_stat_pkg:
  - State enum typedef stat_state_e {IDLE, REQ, WAIT, RESP}.
  - Default width localparams.
  - Struct typedef stat_cmd_t {wr, addr, wdata}.
- One sub-module, ddr_stat_timer: loadable up-counter with terminal-count flag, parameterized by TIMEOUT_CYC.
- Everything else lives in the top module.

Test Plan:
- Write: cmd wr=1 addr=8'h10 wdata=32'hDEAD_BEEF; ack 2 cycles after stat_wr.
  - Required: stat_wr high exactly 1 cycle with addr 8'h10 and wdata DEADBEEF.
  - Required: rsp_valid with rsp_err=0 and rsp_rdata=0.
- Read: cmd rd addr=8'h04; responder acks the cycle after stat_rd with rdata=32'h1234_5678.
  - Required: rsp_rdata=32'h1234_5678, rsp_err=0.
  - Required: rsp_valid asserts 3 cycles after cmd accept.
- Timeout: TIMEOUT_CYC=16, never ack.
  - Required: rsp_err=1 and rsp_rdata=0 exactly 16 cycles after the REQ cycle; timeout_cnt=1.
  - Then a late ack arrives: required no second response.
- Ack/expiry race: ack driven in the terminal-count cycle.
  - Required: rsp_err=0 and timeout_cnt unchanged.
- Backpressure: hold rsp_ready=0 for 10 cycles with a second cmd_valid pending.
  - Required: cmd_ready=0 throughout; response stable; second cmd accepted 1 cycle after rsp handshake.
- Interrupts and reset:
  - stat_int=8'h05 pulse, then int_clr=8'h01 → int_status=8'h04.
  - Same-cycle set+clr on bit 2 → bit stays 1.
  - sync_rst asserted during WAIT → all outputs at reset values next cycle; subsequent ack produces no rsp_valid.
